// File: rtl/div_clk_select.sv
// Glitch-free run-time selector for the clock divider's div4/div8/div80 outputs.
//
// A request (sel_req_i + sel_i) is accepted only while idle. The old source is
// drained until it is low, the output is held low, and the new source is armed
// once it is low too. A clk_out_o high phase is therefore never cut short. Each
// wait is bounded by TIMEOUT_CYCLES; a forced exit raises timeout_err_o.
//
// Optional feature: define DIV_CLK_SELECT_EDGE_COUNT_EN to add edge_count_o, a
// CNT_W-bit wrapping count of clk_out_o rising edges.
//
// Ports:
//   clk            system clock (same clock as the divider)
//   reset          synchronous, active-low
//   div4_i         divider output, period 4 clk
//   div8_i         divider output, period 8 clk
//   div80_i        divider output, period 160 clk
//   sel_req_i      one-cycle request strobe
//   sel_i          requested source: 0=off, 1=div4, 2=div8, 3=div80
//   sel_ack_o      one-cycle pulse when a request completes
//   busy_o         high from the accepted request through the ack cycle
//   active_sel_o   source currently gated to clk_out_o
//   clk_out_o      registered gated clock
//   rise_pulse_o   one-cycle pulse on each 0->1 transition of clk_out_o
//   timeout_err_o  last switch was forced; cleared by the next accepted request
//   edge_count_o   rising-edge count (only with DIV_CLK_SELECT_EDGE_COUNT_EN)
module div_clk_select #(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter int unsigned CNT_W          = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       div4_i,
  input  logic       div8_i,
  input  logic       div80_i,
  input  logic       sel_req_i,
  input  logic [1:0] sel_i,
  output logic       sel_ack_o,
  output logic       busy_o,
  output logic [1:0] active_sel_o,
  output logic       clk_out_o,
  output logic       rise_pulse_o,
  output logic       timeout_err_o
`ifdef DIV_CLK_SELECT_EDGE_COUNT_EN
  ,
  output logic [CNT_W-1:0] edge_count_o
`endif
);

  typedef enum logic [1:0] {StIdle, StDrain, StArm, StDone} state_e;

  localparam logic [15:0] TmoLast = 16'(TIMEOUT_CYCLES - 1);

  state_e      state_q, state_d;
  logic [1:0]  target_q, target_d;
  logic [1:0]  active_sel_q, active_sel_d;
  logic        gate_q, gate_d;
  logic [15:0] tmo_cnt_q, tmo_cnt_d;
  logic        timeout_err_q, timeout_err_d;
  logic        busy_q, busy_d;
  logic        sel_ack_q, sel_ack_d;
  logic        clk_out_q, clk_out_d;
  logic        rise_q, rise_d;
  logic        accept;
  logic        src_old, src_tgt;

  function automatic logic src_mux(input logic [1:0] code, input logic d4, input logic d8,
                                   input logic d80);
    logic s;
    unique case (code)
      2'd0:    s = 1'b0;
      2'd1:    s = d4;
      2'd2:    s = d8;
      default: s = d80;
    endcase
    return s;
  endfunction

  always_comb begin
    src_old = src_mux(active_sel_q, div4_i, div8_i, div80_i);
    src_tgt = src_mux(target_q, div4_i, div8_i, div80_i);
  end

  always_comb begin
    state_d       = state_q;
    target_d      = target_q;
    active_sel_d  = active_sel_q;
    gate_d        = gate_q;
    tmo_cnt_d     = tmo_cnt_q;
    timeout_err_d = timeout_err_q;
    busy_d        = busy_q;
    sel_ack_d     = 1'b0;
    accept        = 1'b0;

    // busy stays up through the ack cycle and drops on the following edge.
    if (sel_ack_q) busy_d = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (sel_req_i && !busy_q) begin
          accept        = 1'b1;
          target_d      = sel_i;
          timeout_err_d = 1'b0;
          busy_d        = 1'b1;
          if (sel_i == active_sel_q) begin
            state_d = StDone;
          end else begin
            state_d   = StDrain;
            tmo_cnt_d = '0;
          end
        end
      end
      StDrain: begin
        if (!src_old || (tmo_cnt_q == TmoLast)) begin
          gate_d    = 1'b0;
          state_d   = StArm;
          tmo_cnt_d = '0;
          if (src_old) timeout_err_d = 1'b1;
        end else begin
          tmo_cnt_d = tmo_cnt_q + 16'd1;
        end
      end
      StArm: begin
        // Arming while the new source is low means the first high phase is whole.
        if (!src_tgt || (tmo_cnt_q == TmoLast)) begin
          active_sel_d = target_q;
          gate_d       = 1'b1;
          state_d      = StDone;
          if (src_tgt) timeout_err_d = 1'b1;
        end else begin
          tmo_cnt_d = tmo_cnt_q + 16'd1;
        end
      end
      StDone: begin
        sel_ack_d = 1'b1;
        state_d   = StIdle;
      end
      default: state_d = StIdle;
    endcase

    clk_out_d = gate_q & src_old;
    rise_d    = clk_out_d & ~clk_out_q;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q       <= StIdle;
      target_q      <= 2'd0;
      active_sel_q  <= 2'd0;
      gate_q        <= 1'b0;
      tmo_cnt_q     <= '0;
      timeout_err_q <= 1'b0;
      busy_q        <= 1'b0;
      sel_ack_q     <= 1'b0;
      clk_out_q     <= 1'b0;
      rise_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      target_q      <= target_d;
      active_sel_q  <= active_sel_d;
      gate_q        <= gate_d;
      tmo_cnt_q     <= tmo_cnt_d;
      timeout_err_q <= timeout_err_d;
      busy_q        <= busy_d;
      sel_ack_q     <= sel_ack_d;
      clk_out_q     <= clk_out_d;
      rise_q        <= rise_d;
    end
  end

  assign sel_ack_o     = sel_ack_q;
  assign busy_o        = busy_q;
  assign active_sel_o  = active_sel_q;
  assign clk_out_o     = clk_out_q;
  assign rise_pulse_o  = rise_q;
  assign timeout_err_o = timeout_err_q;

`ifdef DIV_CLK_SELECT_EDGE_COUNT_EN
  logic [CNT_W-1:0] edge_cnt_q, edge_cnt_d;

  // Counting restarts only when the source actually changes.
  always_comb begin
    edge_cnt_d = edge_cnt_q;
    if (accept && (sel_i != active_sel_q)) begin
      edge_cnt_d = '0;
    end else if (rise_d) begin
      edge_cnt_d = edge_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) edge_cnt_q <= '0;
    else        edge_cnt_q <= edge_cnt_d;
  end

  assign edge_count_o = edge_cnt_q;
`endif

endmodule

// File: tb/tb_div_clk_select.sv
module tb_div_clk_select;

  localparam int unsigned T     = 16;
  localparam int unsigned CNT_W = 4;

  logic       clk;
  logic       reset;
  logic       div4, div8, div80;
  logic       sel_req;
  logic [1:0] sel;
  logic       sel_ack, busy, clk_out, rise_pulse, timeout_err;
  logic [1:0] active_sel;
`ifdef DIV_CLK_SELECT_EDGE_COUNT_EN
  logic [CNT_W-1:0] edge_count;
`endif

  div_clk_select #(
    .TIMEOUT_CYCLES(T),
    .CNT_W         (CNT_W)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .div4_i       (div4),
    .div8_i       (div8),
    .div80_i      (div80),
    .sel_req_i    (sel_req),
    .sel_i        (sel),
    .sel_ack_o    (sel_ack),
    .busy_o       (busy),
    .active_sel_o (active_sel),
    .clk_out_o    (clk_out),
    .rise_pulse_o (rise_pulse),
    .timeout_err_o(timeout_err)
`ifdef DIV_CLK_SELECT_EDGE_COUNT_EN
    ,
    .edge_count_o (edge_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Number of posedges seen so far; stable at every negedge.
  int n_edge = 0;
  always @(posedge clk) n_edge <= n_edge + 1;

  typedef struct {
    int               ed;
    logic             co, rp, bz, er;
    logic [1:0]       act;
    logic [CNT_W-1:0] ec;
  } cyc_t;

  typedef struct {
    int         ed;
    logic [1:0] sel;
    logic       err;
  } ack_t;

  cyc_t cyc_q[$];
  ack_t ack_q[$];

  int n_cmp = 0;
  int n_bad = 0;

  bit stub80   = 1'b0;
  bit rst_now  = 1'b1;

  // Reference model of the current/most recent switch, in absolute edge numbers.
  logic [1:0]       m_old, m_active;
  int               m_acc, m_drain, m_arm, m_ack, m_forced;
  logic             m_prev_clk;
  logic [CNT_W-1:0] m_ecnt;

  // Source levels as a function of the edge number they are sampled at.
  function automatic logic src_at(input logic [1:0] code, input int e);
    case (code)
      2'd0:    return 1'b0;
      2'd1:    return (e % 4) >= 2;
      2'd2:    return (e % 8) >= 4;
      default: return stub80 ? 1'b1 : ((e % 160) >= 80);
    endcase
  endfunction

  task automatic chk(input string nm, input int unsigned got, input int unsigned exp);
    n_cmp++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s at edge %0d: got %0d expected %0d", nm, n_edge, got, exp);
    end
  endtask

  task automatic model_reset();
    m_old = 2'd0; m_active = 2'd0;
    m_acc = -20; m_drain = 0; m_arm = 0; m_ack = -10; m_forced = 0;
    m_prev_clk = 1'b0; m_ecnt = '0;
  endtask

  // Work out the whole switch up front: wait for the old source low, then the new.
  task automatic model_accept(input int e, input logic [1:0] s);
    ack_t a;
    int   d;
    m_old    = m_active;
    m_active = s;
    m_acc    = e;
    m_forced = 0;
    if (s == m_old) begin
      m_drain = e;
      m_arm   = e;
    end else begin
      d = e;
      for (int k = 1; k <= int'(T); k++) begin
        d = e + k;
        if (!src_at(m_old, d)) break;
        if (k == int'(T)) m_forced = d;
      end
      m_drain = d;
      for (int k = 1; k <= int'(T); k++) begin
        d = m_drain + k;
        if (!src_at(s, d)) break;
        if (k == int'(T) && m_forced == 0) m_forced = d;
      end
      m_arm = d;
    end
    m_ack = m_arm + 1;
    a.ed  = m_ack;
    a.sel = s;
    a.err = (m_forced != 0);
    ack_q.push_back(a);
  endtask

  // Drive one clock cycle of stimulus and queue what the DUT must show after that edge.
  task automatic step(input logic req, input logic [1:0] s);
    int   e;
    bit   acc;
    cyc_t c;
    @(negedge clk);
    e       = n_edge + 1;
    reset   = ~rst_now;
    div4    = src_at(2'd1, e);
    div8    = src_at(2'd2, e);
    div80   = src_at(2'd3, e);
    sel_req = req;
    sel     = s;
    acc     = 1'b0;
    c.ed    = e;
    if (rst_now) begin
      while (ack_q.size() > 0 && ack_q[$].ed >= e) void'(ack_q.pop_back());
      model_reset();
      c.co = 1'b0; c.rp = 1'b0; c.bz = 1'b0; c.er = 1'b0; c.act = 2'd0; c.ec = '0;
    end else begin
      if (req && e >= m_ack + 2) begin
        acc = (s != m_active);
        model_accept(e, s);
      end
      c.co  = (e <= m_drain) ? src_at(m_old, e) : (e <= m_arm) ? 1'b0 : src_at(m_active, e);
      c.rp  = c.co & ~m_prev_clk;
      c.bz  = (e >= m_acc) && (e <= m_ack);
      c.er  = (m_forced != 0) && (e >= m_forced);
      c.act = (e >= m_arm) ? m_active : m_old;
      if (acc)       m_ecnt = '0;
      else if (c.rp) m_ecnt = m_ecnt + CNT_W'(1);
      c.ec       = m_ecnt;
      m_prev_clk = c.co;
    end
    cyc_q.push_back(c);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 2'd0);
  endtask

  // Step until source `code` is high at edge n_edge+ahead (bounded by the slowest period).
  task automatic wait_high(input logic [1:0] code, input int ahead);
    for (int i = 0; i < 200; i++) begin
      if (src_at(code, n_edge + ahead)) break;
      step(1'b0, 2'd0);
    end
  endtask

  initial begin : monitor
    cyc_t c;
    ack_t a;
    forever begin
      @(negedge clk);
      while (cyc_q.size() > 0 && cyc_q[0].ed <= n_edge) begin
        c = cyc_q.pop_front();
        if (c.ed == n_edge) begin
          chk("clk_out", clk_out, c.co);
          chk("rise_pulse", rise_pulse, c.rp);
          chk("busy", busy, c.bz);
          chk("timeout_err", timeout_err, c.er);
          chk("active_sel", active_sel, c.act);
`ifdef DIV_CLK_SELECT_EDGE_COUNT_EN
          chk("edge_count", edge_count, c.ec);
`endif
        end
      end
      if (sel_ack === 1'b1) begin
        if (ack_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL spurious_ack at edge %0d: got sel_ack=1 expected 0", n_edge);
        end else begin
          a = ack_q.pop_front();
          chk("ack_edge", n_edge, a.ed);
          chk("ack_active_sel", active_sel, a.sel);
          chk("ack_timeout_err", timeout_err, a.err);
        end
      end
    end
  end

  initial begin : stimulus
    reset = 1'b0; div4 = 1'b0; div8 = 1'b0; div80 = 1'b0; sel_req = 1'b0; sel = 2'd0;
    model_reset();

    // Reset with sources toggling, then stay off after release.
    rst_now = 1'b1;
    idle(3);
    rst_now = 1'b0;
    idle(20);

    // Off -> div4, requested while div4 is high.
    wait_high(2'd1, 1);
    step(1'b1, 2'd1);
    idle(30);

    // div4 -> div80 requested mid div4 high.
    wait_high(2'd1, 1);
    step(1'b1, 2'd3);
    idle(400);

    // Same-select re-request; requests during busy are dropped.
    step(1'b1, 2'd3);
    step(1'b1, 2'd2);
    step(1'b1, 2'd0);
    idle(10);

    // Timeout: div80 stuck high while arming it.
    step(1'b1, 2'd0);
    idle(60);
    stub80 = 1'b1;
    step(1'b1, 2'd3);
    idle(60);
    step(1'b1, 2'd3);
    idle(6);
    step(1'b1, 2'd0);
    idle(60);
    stub80 = 1'b0;
    idle(4);

    // Reset while arming div4 (div4 high at the first ARM cycle).
    wait_high(2'd1, 3);
    step(1'b1, 2'd1);
    step(1'b0, 2'd0);
    rst_now = 1'b1;
    step(1'b0, 2'd0);
    rst_now = 1'b0;
    idle(10);

    // Randomized requests with occasional resets.
    for (int i = 0; i < 4000; i++) begin
      rst_now = ($urandom_range(0, 599) == 0);
      step($urandom_range(0, 5) == 0, 2'($urandom_range(0, 3)));
    end
    rst_now = 1'b0;
    idle(400);

    chk("acks_outstanding", ack_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/div_clk_select.md
Name: div_clk_select

Overview:
- Glitch-free selector downstream of the clock divider. Consumes the divider's registered div4/div8/div80 outputs, all synchronous to clk.
- Drives one gated output clock chosen at run time through a req/ack handshake.
- Switches only when both the old and new sources are low, so clk_out never produces a runt pulse.
- Also supplies a rising-edge strobe for clk-domain logic that times itself off the selected rate.

Parameters:
- TIMEOUT_CYCLES, 255, max cycles spent in DRAIN or ARM before forcing the transition (range 1..65535).
- CNT_W, 16, edge-counter width (used only with the optional feature).

Ports:
- clk  in  1  system clock (same clock as the divider)
- reset  in  1  synchronous, active-low
- div4  in  1  divider output, period 4 clk
- div8  in  1  divider output, period 8 clk
- div80  in  1  divider output, period 160 clk
- sel_req  in  1  one-cycle request strobe
- sel  in  2  requested source: 0=off, 1=div4, 2=div8, 3=div80; sampled with sel_req
- sel_ack  out  1  one-cycle pulse when a request completes
- busy  out  1  high from the accepted request until the ack cycle, inclusive
- active_sel  out  2  source currently gated to clk_out
- clk_out  out  1  registered gated clock
- rise_pulse  out  1  one-cycle pulse on each 0->1 transition of clk_out
- timeout_err  out  1  set if the last switch was forced; held until the next accepted request
- edge_count  out  CNT_W  present only with the optional feature

Behaviour:
- Reset (reset=0 at posedge clk): clk_out=0, active_sel=0, sel_ack=0, busy=0, rise_pulse=0, timeout_err=0, FSM=IDLE, timeout counter=0, edge_count=0.
- Reset has priority over everything, including mid-switch; output is off after reset.
- src(x) means the input selected by code x; src(0)=0.
- clk_out <= gate & src(active_sel), one clk latency from the divider output.
- rise_pulse <= clk_out_next & ~clk_out.
- FSM states: IDLE, DRAIN, ARM, DONE.
- IDLE:
  - sel_req accepted only here; sel_req while busy=1 is ignored and never queued.
  - On accept: target<=sel, timeout_err<=0, busy<=1.
  - If sel==active_sel, go to DONE; clk_out is undisturbed.
  - Otherwise go to DRAIN.
- DRAIN:
  - clk_out keeps following the old source.
  - In the first cycle src(active_sel)==0: gate<=0, go to ARM.
- ARM:
  - clk_out held 0.
  - In the first cycle src(target)==0: active_sel<=target, gate<=1, go to DONE.
  - The new source starts low, so no partial high phase appears.
- DONE: sel_ack=1 for exactly one cycle, busy<=0, go to IDLE.
- Timeout:
  - Counter clears on entry to DRAIN and ARM and increments each cycle spent in either state.
  - On reaching TIMEOUT_CYCLES, take the state's exit action regardless of source level and set timeout_err=1.
  - A forced ARM exit may produce a short first high phase; this is accepted and flagged.
- Switching off (target 0): ARM completes in its first cycle.
- Guarantees:
  - Every clk_out high phase equals a full source high phase, except after a forced exit.
  - Low phase across a switch lasts ≥1 clk.
- Request-to-ack latency: 2 cycles if sel==active_sel; otherwise ≤ 2·TIMEOUT_CYCLES+3 cycles.

Optional Feature:
- Macro: DIV_CLK_SELECT_EDGE_COUNT_EN.
- Defined:
  - Adds edge_count, which increments on every rise_pulse and wraps at 2^CNT_W−1 -> 0.
  - Clears on reset and on each accepted request whose sel differs from active_sel.
- Undefined: the port and counter are absent; all other behaviour is identical.

Test Plan:
- Reset: drive reset=0 for 3 clk with sources toggling -> all outputs 0; clk_out stays 0 for 20 clk after release.
- Off->div4: pulse sel_req, sel=1 while div4=1 -> ack within 4 clk, active_sel=1; clk_out then has period 4 (2 high/2 low), first high phase full 2 clk, rise_pulse every 4 clk.
- div4->div80 requested mid div4 high -> DRAIN waits for div4 low, ARM waits for div80 low; no clk_out high phase shorter than 2 clk; then 80 high/80 low; timeout_err=0.
- Same-select plus busy: re-request sel=3 while active_sel=3 -> ack exactly 2 clk later, clk_out uninterrupted; a sel_req during busy is ignored and produces no second ack.
- Timeout: TIMEOUT_CYCLES=16, div80 stubbed high, request off->div80 -> ARM forced after 16 cycles, ack follows, timeout_err=1; next accepted request clears it.
- Reset mid-switch: assert reset while in ARM -> next cycle active_sel=0, busy=0, clk_out=0, no ack. With DIV_CLK_SELECT_EDGE_COUNT_EN and CNT_W=4: 17 div4 edges -> edge_count=1.
